trap_sequencer: RTL and testbench

- Sequences the machine-mode trap entry/exit datapath: detects ECALL/EBREAK/MRET in ID and pending external/timer interrupts.
- Drives the dedicated (non-EX) write port of the CSR register file one CSR per cycle.
- Stalls the pipeline while sequencing, then issues a one-cycle PC redirect to the handler or return address.
- Sits beside the ID stage; consumes live mstatus/mepc/mtvec from the CSR file.

---
 rtl/trap_sequencer.sv | 149 ++++++++++++++
 tb/tb_trap_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/exit sequencer: detects ECALL/EBREAK/MRET and pending
// interrupts in ID, writes mepc/mcause/mstatus one per cycle, then redirects the PC.
module trap_sequencer #(
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        ex_jump_flag_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mtvec_i,
  output logic        stall_o,
  output logic        csr_we_o,
  output logic [11:0] csr_wa_o,
  output logic [31:0] csr_wd_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_addr_o
);

  localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] INST_MRET    = 32'h3020_0073;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    W_MRET,
    REDIRECT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        mret_q, mret_d;

  logic        is_ecall, is_ebreak, is_mret, irq_pend, idle, detect;
  logic [31:0] async_epc;

  always_comb begin
    is_ecall  = inst_valid_i && (inst_i == INST_ECALL);
    is_ebreak = inst_valid_i && (inst_i == INST_EBREAK);
    is_mret   = inst_valid_i && (inst_i == INST_MRET);
    irq_pend  = csr_mstatus_i[3] && (irq_ext_i || irq_timer_i);
    idle      = (state_q == IDLE) && !rst_i;
    detect    = idle && (is_mret || is_ecall || is_ebreak || irq_pend);
    // An interrupt resumes where EX was heading if EX is redirecting this cycle
    async_epc = ex_jump_flag_i ? ex_jump_addr_i : inst_addr_i;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    mret_d  = mret_q;
    case (state_q)
      IDLE: begin
        if (is_mret) begin
          state_d = W_MRET;
          mret_d  = 1'b1;
        end else if (is_ecall || is_ebreak) begin
          state_d = W_MEPC;
          mret_d  = 1'b0;
          epc_d   = inst_addr_i;
          cause_d = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
        end else if (irq_pend) begin
          state_d = W_MEPC;
          mret_d  = 1'b0;
          epc_d   = async_epc;
          cause_d = irq_ext_i ? CAUSE_EXT : CAUSE_TIMER;
        end
      end
      W_MEPC:    state_d = W_MCAUSE;
      W_MCAUSE:  state_d = W_MSTATUS;
      W_MSTATUS: state_d = REDIRECT;
      W_MRET:    state_d = REDIRECT;
      REDIRECT:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      mret_q  <= mret_d;
    end
  end

  // Outputs decode the current state; mstatus/mepc/mtvec are read live
  always_comb begin
    stall_o          = 1'b0;
    csr_we_o         = 1'b0;
    csr_wa_o         = '0;
    csr_wd_o         = '0;
    redirect_valid_o = 1'b0;
    redirect_addr_o  = '0;
    if (!rst_i) begin
      stall_o = (state_q != IDLE) || detect;
      case (state_q)
        W_MEPC: begin
          csr_we_o = 1'b1;
          csr_wa_o = CSR_MEPC;
          csr_wd_o = epc_q;
        end
        W_MCAUSE: begin
          csr_we_o = 1'b1;
          csr_wa_o = CSR_MCAUSE;
          csr_wd_o = cause_q;
        end
        W_MSTATUS: begin
          csr_we_o = 1'b1;
          csr_wa_o = CSR_MSTATUS;
          csr_wd_o = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
        end
        W_MRET: begin
          csr_we_o = 1'b1;
          csr_wa_o = CSR_MSTATUS;
          csr_wd_o = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
        end
        REDIRECT: begin
          redirect_valid_o = 1'b1;
          redirect_addr_o  = mret_q ? csr_mepc_i : (csr_mtvec_i & 32'hFFFF_FFFC);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized and directed check of trap_sequencer against a per-cycle expectation queue
// derived from the trap/MRET rules; the bench also plays the role of the CSR file.
module tb_trap_sequencer;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  typedef struct packed {
    logic        stall;
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] ra;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, instValid, jumpFlag, irqExt, irqTimer;
  logic [31:0] inst, instAddr, jumpAddr;
  logic [31:0] mstM, mepcM, mcauseM, mtvecM;
  logic        stall, csrWe, redirValid;
  logic [11:0] csrWa;
  logic [31:0] csrWd, redirAddr;

  exp_t        expQ[$];
  exp_t        curExp;
  int          total, bad;
  logic        ovEn;
  logic [31:0] ovMst, ovMepc, ovMtvec;

  always #5 clk = ~clk;

  trap_sequencer dut (
    .clk_i(clk), .rst_i(rst), .inst_valid_i(instValid), .inst_i(inst), .inst_addr_i(instAddr),
    .ex_jump_flag_i(jumpFlag), .ex_jump_addr_i(jumpAddr), .irq_ext_i(irqExt), .irq_timer_i(irqTimer),
    .csr_mstatus_i(mstM), .csr_mepc_i(mepcM), .csr_mtvec_i(mtvecM),
    .stall_o(stall), .csr_we_o(csrWe), .csr_wa_o(csrWa), .csr_wd_o(csrWd),
    .redirect_valid_o(redirValid), .redirect_addr_o(redirAddr)
  );

  function automatic exp_t mkRec(logic s, logic w, logic [11:0] a, logic [31:0] d, logic v, logic [31:0] r);
    exp_t e;
    e.stall = s; e.we = w; e.wa = a; e.wd = d; e.rv = v; e.ra = r;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s @%0t observed=%h expected=%h", tag, $time, obs, expv);
    end
  endtask

  task automatic queueCsr(input logic [31:0] m, input logic [31:0] e, input logic [31:0] t);
    ovEn = 1'b1; ovMst = m; ovMepc = e; ovMtvec = t;
  endtask

  // Expected outputs for this cycle: either the next step of a sequence already
  // scheduled, or a fresh decision taken from this cycle's inputs.
  task automatic computeExpected();
    logic [31:0] newMst, cause, epc;
    logic        trap;
    if (rst) begin
      expQ.delete();
      curExp = '0;
      return;
    end
    if (expQ.size() > 0) begin
      curExp = expQ.pop_front();
      return;
    end
    curExp = '0;
    trap = 1'b0;
    cause = 32'd0;
    epc = instAddr;
    if (instValid && inst == MRET) begin
      newMst = mstM;
      newMst[3] = mstM[7];
      newMst[7] = 1'b1;
      curExp.stall = 1'b1;
      expQ.push_back(mkRec(1'b1, 1'b1, 12'h300, newMst, 1'b0, 32'd0));
      expQ.push_back(mkRec(1'b1, 1'b0, 12'h000, 32'd0, 1'b1, mepcM));
    end else if (instValid && inst == ECALL) begin
      trap = 1'b1; cause = 32'd11;
    end else if (instValid && inst == EBREAK) begin
      trap = 1'b1; cause = 32'd3;
    end else if (mstM[3] && (irqExt || irqTimer)) begin
      trap = 1'b1;
      cause = irqExt ? 32'h8000_000B : 32'h8000_0007;
      if (jumpFlag) epc = jumpAddr;
    end
    if (trap) begin
      newMst = mstM;
      newMst[7] = mstM[3];
      newMst[3] = 1'b0;
      curExp.stall = 1'b1;
      expQ.push_back(mkRec(1'b1, 1'b1, 12'h341, epc, 1'b0, 32'd0));
      expQ.push_back(mkRec(1'b1, 1'b1, 12'h342, cause, 1'b0, 32'd0));
      expQ.push_back(mkRec(1'b1, 1'b1, 12'h300, newMst, 1'b0, 32'd0));
      expQ.push_back(mkRec(1'b1, 1'b0, 12'h000, 32'd0, 1'b1, mtvecM & 32'hFFFF_FFFC));
    end
  endtask

  task automatic checkOutput();
    chk("stall", {31'd0, stall}, {31'd0, curExp.stall});
    chk("csr_we", {31'd0, csrWe}, {31'd0, curExp.we});
    chk("csr_wa", {20'd0, csrWa}, {20'd0, curExp.wa});
    chk("csr_wd", csrWd, curExp.wd);
    chk("redirect_valid", {31'd0, redirValid}, {31'd0, curExp.rv});
    chk("redirect_addr", redirAddr, curExp.ra);
  endtask

  // One clock cycle: retire the previous cycle's CSR write into the bench CSR file,
  // drive new inputs at the falling edge, then compare against the expectation.
  task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [31:0] a,
                               input logic jf, input logic [31:0] ja,
                               input logic ext, input logic tmr, input logic r);
    @(negedge clk);
    if (curExp.we) begin
      case (curExp.wa)
        12'h300: mstM = curExp.wd;
        12'h341: mepcM = curExp.wd;
        12'h342: mcauseM = curExp.wd;
        default: ;
      endcase
    end
    if (ovEn) begin
      mstM = ovMst; mepcM = ovMepc; mtvecM = ovMtvec; ovEn = 1'b0;
    end
    instValid = v; inst = i; instAddr = a; jumpFlag = jf; jumpAddr = ja;
    irqExt = ext; irqTimer = tmr; rst = r;
    #1;
    computeExpected();
    checkOutput();
  endtask

  initial begin
    logic [31:0] pick;
    total = 0; bad = 0; ovEn = 1'b0; curExp = '0;
    rst = 1'b1; instValid = 1'b0; inst = '0; instAddr = '0; jumpFlag = 1'b0; jumpAddr = '0;
    irqExt = 1'b0; irqTimer = 1'b0;
    mstM = '0; mepcM = '0; mcauseM = '0; mtvecM = '0;

    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, ECALL, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    chk("reset_stall", {31'd0, stall}, 32'd0);

    // ECALL entry sequence with literal expectations
    queueCsr(32'h8, 32'h0, 32'h201);
    applyStimulus(1'b1, ECALL, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("ecall_T_stall", {31'd0, stall}, 32'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("ecall_mepc", csrWd, 32'h100);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("ecall_mcause", csrWd, 32'd11);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("ecall_mstatus", csrWd, 32'h80);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("ecall_redirect", redirAddr, 32'h200);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("ecall_done_stall", {31'd0, stall}, 32'd0);

    // Reset while writing mcause aborts the sequence
    queueCsr(32'h8, 32'h0, 32'h201);
    applyStimulus(1'b1, EBREAK, 32'h180, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_we", {31'd0, csrWe}, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("abort_redirect", {31'd0, redirValid}, 32'd0);

    // MRET restores MIE and returns to mepc
    queueCsr(32'h80, 32'h104, 32'h201);
    applyStimulus(1'b1, MRET, 32'h300, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("mret_mstatus", csrWd, 32'h88);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("mret_redirect", redirAddr, 32'h104);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("mret_done_stall", {31'd0, stall}, 32'd0);

    // External interrupt while EX redirects: mepc takes the jump target
    queueCsr(32'h8, 32'h0, 32'h1000);
    applyStimulus(1'b0, 32'd0, 32'h120, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("irq_mepc", csrWd, 32'h400);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("irq_mcause", csrWd, 32'h8000_000B);
    repeat (3) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Timer masked by MIE=0, then taken once MIE is set
    queueCsr(32'h0, 32'h0, 32'h1000);
    repeat (3) applyStimulus(1'b0, 32'd0, 32'h140, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("masked_stall", {31'd0, stall}, 32'd0);
    queueCsr(32'h8, 32'h0, 32'h1000);
    applyStimulus(1'b0, 32'd0, 32'h140, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("timer_T_stall", {31'd0, stall}, 32'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("timer_mcause", csrWd, 32'h8000_0007);
    repeat (3) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // ECALL beats a simultaneous external interrupt; the interrupt follows back-to-back
    queueCsr(32'h8, 32'h0, 32'h1000);
    applyStimulus(1'b1, ECALL, 32'h200, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("prio_mcause", csrWd, 32'd11);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    queueCsr(32'h88, mepcM, 32'h1000);
    applyStimulus(1'b0, 32'd0, 32'h204, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("b2b_stall", {31'd0, stall}, 32'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("b2b_mcause", csrWd, 32'h8000_000B);
    repeat (3) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Random traffic; CSR contents only change between sequences
    for (int n = 0; n < 800; n++) begin
      if (expQ.size() == 0 && $urandom_range(0, 3) == 0)
        queueCsr($urandom, $urandom, $urandom);
      case ($urandom_range(0, 5))
        0: pick = ECALL;
        1: pick = EBREAK;
        2: pick = MRET;
        default: pick = $urandom;
      endcase
      applyStimulus($urandom_range(0, 1) == 1, pick, $urandom, $urandom_range(0, 3) == 0, $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
